// File: rtl/ssd_scan_decoder.sv
// Receive side of the multiplexed 4-digit seven-segment scan: rebuilds the
// displayed hex digits and dot points from the shared anode/cathode nets.
module ssd_scan_decoder #(
    parameter int STABLE_CYCLES = 16,
    parameter int TIMEOUT_BITS  = 22
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [3:0]  An,
    input  logic [7:0]  Cath,
    output logic [15:0] Digits,
    output logic [3:0]  DpOut,
    output logic [3:0]  DigitValid,
    output logic        FrameDone,
    output logic        BadCode,
    output logic        AnErr,
    output logic        NoScan
);

    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_CAPTURE = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    // Returns {legal, value}; the segment field is abcdefg with 0 = lit.
    function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
        case (seg)
            7'b0000001: glyph_decode = {1'b1, 4'h0};
            7'b1001111: glyph_decode = {1'b1, 4'h1};
            7'b0010010: glyph_decode = {1'b1, 4'h2};
            7'b0000110: glyph_decode = {1'b1, 4'h3};
            7'b1001100: glyph_decode = {1'b1, 4'h4};
            7'b0100100: glyph_decode = {1'b1, 4'h5};
            7'b0100000: glyph_decode = {1'b1, 4'h6};
            7'b0001111: glyph_decode = {1'b1, 4'h7};
            7'b0000000: glyph_decode = {1'b1, 4'h8};
            7'b0000100: glyph_decode = {1'b1, 4'h9};
            7'b0001000: glyph_decode = {1'b1, 4'hA};
            7'b1100000: glyph_decode = {1'b1, 4'hB};
            7'b0110001: glyph_decode = {1'b1, 4'hC};
            7'b1000010: glyph_decode = {1'b1, 4'hD};
            7'b0110000: glyph_decode = {1'b1, 4'hE};
            7'b0111000: glyph_decode = {1'b1, 4'hF};
            default:    glyph_decode = {1'b0, 4'h0};
        endcase
    endfunction

    logic [11:0]             sync1_r, sync2_r, cap_r;
    logic [CW-1:0]           cnt_r;
    state_t                  state_r;
    logic [3:0]              seen_r;
    logic [TIMEOUT_BITS-1:0] wd_r;

    logic [3:0] low_s, seen_next_s;
    logic [1:0] pos_s;
    logic       onehot_s, multi_s, all_off_s, capture_s, onehot_cap_s;
    logic [4:0] dec_s;

    // Two-flop synchronizer and run-length counter of the synchronized sample.
    // The counter looks one stage ahead so it clears on the same edge the sample changes.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_r <= 12'd0;
            sync2_r <= 12'd0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= {An, Cath};
            sync2_r <= sync1_r;
            if (sync1_r != sync2_r) begin
                cnt_r <= '0;
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Classify the latched slot: anode population, position and glyph.
    always_comb begin
        low_s     = ~cap_r[11:8];
        onehot_s  = 1'b0;
        multi_s   = 1'b0;
        pos_s     = 2'd0;
        case (low_s)
            4'b0000: onehot_s = 1'b0;
            4'b0001: begin onehot_s = 1'b1; pos_s = 2'd0; end
            4'b0010: begin onehot_s = 1'b1; pos_s = 2'd1; end
            4'b0100: begin onehot_s = 1'b1; pos_s = 2'd2; end
            4'b1000: begin onehot_s = 1'b1; pos_s = 2'd3; end
            default: multi_s = 1'b1;
        endcase
        dec_s        = glyph_decode(cap_r[7:1]);
        all_off_s    = (cap_r[7:1] == 7'h7F);
        capture_s    = (state_r == S_CAPTURE);
        onehot_cap_s = capture_s & onehot_s;
        if (onehot_cap_s) begin
            seen_next_s = seen_r | (4'b0001 << pos_s);
        end else begin
            seen_next_s = seen_r;
        end
    end

    // Slot FSM, digit/flag update and no-scan watchdog.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r    <= S_WAIT;
            cap_r      <= 12'd0;
            seen_r     <= 4'd0;
            wd_r       <= '0;
            Digits     <= 16'd0;
            DpOut      <= 4'd0;
            DigitValid <= 4'd0;
            FrameDone  <= 1'b0;
            BadCode    <= 1'b0;
            AnErr      <= 1'b0;
            NoScan     <= 1'b0;
        end else begin
            FrameDone <= 1'b0;
            BadCode   <= 1'b0;
            case (state_r)
                S_WAIT: begin
                    if (cnt_r == CNT_MAX) begin
                        cap_r   <= sync2_r;
                        state_r <= S_CAPTURE;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_CAPTURE: state_r <= S_HOLD;
                S_HOLD: begin
                    if (sync2_r != cap_r) begin
                        state_r <= S_WAIT;
                    end else begin
                        state_r <= S_HOLD;
                    end
                end
                default: state_r <= S_WAIT;
            endcase

            if (capture_s && multi_s) begin
                AnErr <= 1'b1;
            end else if (onehot_cap_s) begin
                if (all_off_s) begin
                    DigitValid[pos_s] <= 1'b0;
                end else if (dec_s[4]) begin
                    Digits[{pos_s, 2'b00} +: 4] <= dec_s[3:0];
                    DigitValid[pos_s]           <= 1'b1;
                    DpOut[pos_s]                <= ~cap_r[0];
                end else begin
                    BadCode           <= 1'b1;
                    DigitValid[pos_s] <= 1'b0;
                    DpOut[pos_s]      <= ~cap_r[0];
                end
                if (seen_next_s == 4'b1111) begin
                    seen_r    <= 4'b0000;
                    FrameDone <= 1'b1;
                end else begin
                    seen_r <= seen_next_s;
                end
            end else begin
                seen_r <= seen_r;
            end

            // A real capture always wins over expiry on the same edge.
            if (onehot_cap_s) begin
                wd_r   <= '0;
                NoScan <= 1'b0;
            end else if (wd_r == {TIMEOUT_BITS{1'b1}}) begin
                NoScan     <= 1'b1;
                DigitValid <= 4'b0000;
            end else begin
                wd_r <= wd_r + TIMEOUT_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Scoreboard bench for ssd_scan_decoder: slot-level reference model feeds an
// expected-event queue, a monitor pops on every visible output change.
module tb_ssd_scan_decoder;

    localparam int S  = 16;
    localparam int T  = 6;
    localparam longint TO = 64'd1 << T;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [3:0]  An = 4'b1111;
    logic [7:0]  Cath = 8'hFF;
    logic [15:0] Digits;
    logic [3:0]  DpOut, DigitValid;
    logic        FrameDone, BadCode, AnErr, NoScan;

    ssd_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_BITS(T)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .An(An), .Cath(Cath),
        .Digits(Digits), .DpOut(DpOut), .DigitValid(DigitValid),
        .FrameDone(FrameDone), .BadCode(BadCode), .AnErr(AnErr), .NoScan(NoScan)
    );

    always #5 Clk = ~Clk;

    longint cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [27:0] v; longint t; } exp_t;
    exp_t exp_q[$];

    // Glyphs abcdefg, 0 = lit, indexed by hex value.
    logic [6:0] gly [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    logic [3:0]  m_digit [4];
    logic [3:0]  m_dv, m_dp, m_seen;
    logic        m_anerr, m_ns;
    longint      last_cap;
    logic [25:0] m_prev;
    logic [11:0] last_in;

    function automatic logic [25:0] m_state();
        return {m_digit[3], m_digit[2], m_digit[1], m_digit[0], m_dv, m_dp, m_anerr, m_ns};
    endfunction

    function automatic bit is_legal(input logic [6:0] seg);
        for (int v = 0; v < 16; v++) if (gly[v] == seg) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_reset(input longint t);
        for (int i = 0; i < 4; i++) m_digit[i] = 4'd0;
        m_dv = 4'd0; m_dp = 4'd0; m_seen = 4'd0;
        m_anerr = 1'b0; m_ns = 1'b0;
        last_cap = t; m_prev = 26'd0;
    endtask

    task automatic push(input bit fd, input bit bc, input longint t);
        exp_t e;
        e.v = {m_state(), fd, bc};
        e.t = t;
        exp_q.push_back(e);
        m_prev = m_state();
    endtask

    // Watchdog expiry happens 2^T edges after the last one-hot capture (or reset release).
    task automatic m_expire(input longint t, input bit is_cap, input bit cap_onehot);
        longint e;
        e = last_cap + TO;
        if (!m_ns) begin
            if (is_cap) begin
                if (e < t) begin
                    m_ns = 1'b1; m_dv = 4'd0; push(1'b0, 1'b0, e);
                end else if (e == t && !cap_onehot) begin
                    m_ns = 1'b1; m_dv = 4'd0;
                end
            end else if (e <= t) begin
                m_ns = 1'b1; m_dv = 4'd0; push(1'b0, 1'b0, e);
            end
        end
    endtask

    task automatic m_capture(input logic [3:0] an, input logic [7:0] cath, input longint t);
        int nlow, p, val;
        bit fd, bc, legal;
        nlow = 0; p = 0; fd = 1'b0; bc = 1'b0; legal = 1'b0; val = 0;
        for (int i = 0; i < 4; i++) if (!an[i]) begin nlow++; p = i; end
        m_expire(t, 1'b1, nlow == 1);
        if (nlow > 1) begin
            m_anerr = 1'b1;
        end else if (nlow == 1) begin
            for (int v = 0; v < 16; v++) if (gly[v] == cath[7:1]) begin legal = 1'b1; val = v; end
            if (cath[7:1] == 7'h7F) begin
                m_dv[p] = 1'b0;
            end else if (legal) begin
                m_digit[p] = val[3:0]; m_dv[p] = 1'b1; m_dp[p] = ~cath[0];
            end else begin
                bc = 1'b1; m_dv[p] = 1'b0; m_dp[p] = ~cath[0];
            end
            m_seen[p] = 1'b1;
            if (m_seen == 4'hF) begin fd = 1'b1; m_seen = 4'd0; end
            m_ns = 1'b0;
            last_cap = t;
        end
        if (fd || bc || m_state() != m_prev) push(fd, bc, t);
    endtask

    // Called at a negedge; holds the pattern for 'hold' edges and returns at a negedge.
    task automatic slot(input logic [3:0] an, input logic [7:0] cath, input int hold);
        longint c0;
        An = an; Cath = cath; last_in = {an, cath};
        c0 = cyc;
        if (hold >= S) m_capture(an, cath, c0 + S + 3);
        m_expire(c0 + hold, 1'b0, 1'b0);
        repeat (hold) @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic random_slot();
        logic [3:0] an;
        logic [7:0] cath;
        logic [6:0] seg;
        int r, hold;
        do begin
            r = $urandom_range(0, 99);
            hold = $urandom_range(S + 4, S + 40);
            an = ~(4'b0001 << $urandom_range(0, 3));
            cath = {gly[$urandom_range(0, 15)], 1'($urandom_range(0, 1))};
            if (r >= 55 && r < 62) begin
                do seg = 7'($urandom); while (is_legal(seg) || seg == 7'h7F);
                cath = {seg, 1'($urandom_range(0, 1))};
            end else if (r >= 62 && r < 68) begin
                cath = {7'h7F, 1'($urandom_range(0, 1))};
            end else if (r >= 68 && r < 80) begin
                an = 4'b1111; cath = 8'($urandom);
            end else if (r >= 80 && r < 83) begin
                do an = 4'($urandom); while ($countones(~an) < 2);
            end else if (r >= 83) begin
                an = 4'($urandom); cath = 8'($urandom);
                hold = $urandom_range(1, S - 1);
            end
        end while ({an, cath} == last_in);
        slot(an, cath, hold);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({Digits, DpOut, DigitValid, FrameDone, BadCode, AnErr, NoScan} !== 29'd0) begin
            errors++;
            $display("FAIL %s: got %h, required all-zero outputs", name,
                     {Digits, DpOut, DigitValid, FrameDone, BadCode, AnErr, NoScan});
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events still pending, required 0", name, exp_q.size());
        end
    endtask

    // Monitor: every visible output change or pulse must match the next expected event.
    logic [25:0] prev_p = 26'd0;
    always @(posedge Clk) begin
        logic [25:0] cur;
        exp_t e;
        #1;
        if (!Reset_n) begin
            prev_p = 26'd0;
        end else begin
            cur = {Digits, DigitValid, DpOut, AnErr, NoScan};
            if (cur != prev_p || FrameDone || BadCode) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: cycle=%0d got=%h, required no change",
                             cyc, {cur, FrameDone, BadCode});
                end else begin
                    e = exp_q.pop_front();
                    if ({cur, FrameDone, BadCode} !== e.v || cyc != e.t) begin
                        errors++;
                        $display("FAIL event: got %h at cycle %0d, required %h at cycle %0d",
                                 {cur, FrameDone, BadCode}, cyc, e.v, e.t);
                    end
                end
            end
            prev_p = cur;
        end
    end

    initial begin
        logic [3:0] an_v;
        logic [7:0] cath_v;
        m_reset(0);
        last_in = {An, Cath};
        repeat (3) @(negedge Clk);
        check_zero("reset_state");
        Reset_n = 1'b1;
        m_reset(cyc);

        // 1,2,A,F on digits 3..0, Dp off, 64-cycle slots
        slot(4'b0111, {7'b1001111, 1'b1}, 64);
        slot(4'b1011, {7'b0010010, 1'b1}, 64);
        slot(4'b1101, {7'b0001000, 1'b1}, 64);
        slot(4'b1110, {7'b0111000, 1'b1}, 64);
        // 8 with dot on digit 2, then all-segments-off at digit 2
        slot(4'b1011, 8'b00000000, 40);
        slot(4'b1110, {7'b0000001, 1'b1}, 40);
        slot(4'b1011, 8'b11111111, 40);
        // illegal glyph at digit 1, then a short glitch
        slot(4'b1101, {7'b1010101, 1'b1}, 40);
        slot(4'($urandom), 8'($urandom), 5);
        slot(4'b1111, 8'hFF, 40);
        // multiple anodes low, then legal scans
        slot(4'b0011, {7'b0000110, 1'b1}, 40);
        slot(4'b0111, {7'b1001100, 1'b0}, 40);
        slot(4'b1110, {7'b0100100, 1'b1}, 40);
        // no scan long enough for the watchdog, then a digit-0 slot
        slot(4'b1111, 8'hFF, 70);
        slot(4'b1110, {7'b0000001, 1'b1}, 40);

        for (int i = 0; i < 150; i++) random_slot();

        // reset in the middle of a stable slot, then the same slot after release
        an_v = 4'b1101; cath_v = {7'b0000110, 1'b1};
        if ({an_v, cath_v} == last_in) cath_v = {7'b1001111, 1'b1};
        slot(an_v, cath_v, 10);
        Reset_n = 1'b0;
        check_drained("drained_before_reset");
        repeat (3) @(negedge Clk);
        check_zero("mid_slot_reset");
        Reset_n = 1'b1;
        m_reset(cyc);
        slot(an_v, cath_v, 40);

        for (int i = 0; i < 20; i++) random_slot();
        check_drained("final_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
